// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID boundary: instruction field positions, NOP encoding,
// load-use FSM states and a saturating counter helper.
package if_id_stage_pkg;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } lu_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_stage_load_use_detect.sv
// Combinational MIPS load-use hazard check of the instruction in ID against a load in EX.
// Zero latency; mask_i suppresses the hazard while the stage is already spending its stall cycle.
module load_use_detect
    import if_id_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [DW-1:0] id_inst_i,
    input  logic          id_valid_i,
    input  logic          ex_memread_i,
    input  logic [RW-1:0] ex_rt_i,
    input  logic          mask_i,
    output logic          hz_o
);

    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          src_match;

    assign rs = id_inst_i[RS_MSB:RS_LSB];
    assign rt = id_inst_i[RT_MSB:RT_LSB];

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign src_match = (ex_rt_i != '0) && ((ex_rt_i == rs) || (ex_rt_i == rt));
    assign hz_o      = id_valid_i & ex_memread_i & src_match & ~mask_i;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with valid tracking, branch/jump squash and load-use stall generation.
// Optional performance counters are built when IF_ID_PERF_EN is defined.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int          DW       = 32,
    parameter int          RW       = 5,
    parameter logic [DW-1:0] NOP_WORD = if_id_stage_pkg::NOP_WORD
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] IF_Inst,
    input  logic [DW-1:0] IF_PC,
    input  logic          Branch,
    input  logic          Jump,
    input  logic          ext_stall,
    input  logic          EX_MemRead,
    input  logic [RW-1:0] EX_Rt,
    output logic [DW-1:0] ID_Inst,
    output logic [DW-1:0] ID_PC,
    output logic          ID_Valid,
    output logic          stall,
    output logic          bubble
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]   lu_stall_cnt,
    output logic [31:0]   flush_cnt
`endif
);

    logic [DW-1:0] id_inst_q, id_inst_d;
    logic [DW-1:0] id_pc_q,   id_pc_d;
    logic          id_valid_q, id_valid_d;
    lu_state_e     state_q, state_d;

    logic flush;
    logic hz;
    logic hz_live;

    assign flush = Branch | Jump;

    load_use_detect #(
        .DW (DW),
        .RW (RW)
    ) u_load_use_detect (
        .id_inst_i    (id_inst_q),
        .id_valid_i   (id_valid_q),
        .ex_memread_i (EX_MemRead),
        .ex_rt_i      (EX_Rt),
        .mask_i       (state_q == LU_STALL),
        .hz_o         (hz)
    );

    // A flush outranks the hazard so the fetch redirect is never held off.
    assign hz_live = hz & ~flush;
    assign stall   = reset & (ext_stall | hz_live);
    assign bubble  = reset & hz_live & ~ext_stall;

    always_comb begin
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        state_d    = state_q;
        if (!ext_stall) begin
            if (flush) begin
                id_inst_d  = NOP_WORD;
                id_pc_d    = IF_PC;
                id_valid_d = 1'b0;
                state_d    = RUN;
            end else if (hz) begin
                state_d    = LU_STALL;
            end else begin
                id_inst_d  = IF_Inst;
                id_pc_d    = IF_PC;
                id_valid_d = 1'b1;
                state_d    = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            id_inst_q  <= NOP_WORD;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
            state_q    <= RUN;
        end else begin
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
            state_q    <= state_d;
        end
    end

    assign ID_Inst  = id_inst_q;
    assign ID_PC    = id_pc_q;
    assign ID_Valid = id_valid_q;

`ifdef IF_ID_PERF_EN
    logic [31:0] lu_stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // bubble is asserted exactly on the edges that take RUN into LU_STALL.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lu_stall_cnt_q <= '0;
            flush_cnt_q    <= '0;
        end else begin
            if (bubble)
                lu_stall_cnt_q <= sat_inc(lu_stall_cnt_q);
            if (flush && !ext_stall)
                flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign lu_stall_cnt = lu_stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural model of the pipeline register.
module tb_if_id_stage;

    logic        clk;
    logic        reset;
    logic [31:0] IF_Inst;
    logic [31:0] IF_PC;
    logic        Branch;
    logic        Jump;
    logic        ext_stall;
    logic        EX_MemRead;
    logic [4:0]  EX_Rt;
    logic [31:0] ID_Inst;
    logic [31:0] ID_PC;
    logic        ID_Valid;
    logic        stall;
    logic        bubble;
`ifdef IF_ID_PERF_EN
    logic [31:0] lu_stall_cnt;
    logic [31:0] flush_cnt;
`endif

    if_id_stage dut (
        .clk        (clk),
        .reset      (reset),
        .IF_Inst    (IF_Inst),
        .IF_PC      (IF_PC),
        .Branch     (Branch),
        .Jump       (Jump),
        .ext_stall  (ext_stall),
        .EX_MemRead (EX_MemRead),
        .EX_Rt      (EX_Rt),
        .ID_Inst    (ID_Inst),
        .ID_PC      (ID_PC),
        .ID_Valid   (ID_Valid),
        .stall      (stall),
        .bubble     (bubble)
`ifdef IF_ID_PERF_EN
        ,
        .lu_stall_cnt (lu_stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: what decode currently holds, and whether this instruction already paid its stall.
    logic [31:0] m_inst, m_pc;
    logic        m_valid;
    logic        m_paid;
    logic [31:0] m_lu_cnt, m_fl_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_hz();
        logic [4:0] rs, rt;
        rs = m_inst[25:21];
        rt = m_inst[20:16];
        return reset && m_valid && EX_MemRead && (EX_Rt != 5'd0)
               && (EX_Rt == rs || EX_Rt == rt) && !m_paid;
    endfunction

    task automatic compare_all();
        logic h, f;
        h = model_hz();
        f = Branch | Jump;
        chk("stall",    {31'd0, stall},    {31'd0, reset & (ext_stall | (h & ~f))});
        chk("bubble",   {31'd0, bubble},   {31'd0, reset & h & ~f & ~ext_stall});
        chk("ID_Inst",  ID_Inst,           m_inst);
        chk("ID_PC",    ID_PC,             m_pc);
        chk("ID_Valid", {31'd0, ID_Valid}, {31'd0, m_valid});
`ifdef IF_ID_PERF_EN
        chk("lu_stall_cnt", lu_stall_cnt, m_lu_cnt);
        chk("flush_cnt",    flush_cnt,    m_fl_cnt);
`endif
    endtask

    task automatic model_edge();
        logic h;
        h = model_hz();
        if (!reset) begin
            m_inst = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_paid = 1'b0;
            m_lu_cnt = 32'h0; m_fl_cnt = 32'h0;
        end else if (ext_stall) begin
            // frozen: nothing moves
        end else if (Branch || Jump) begin
            m_inst = 32'h0; m_pc = IF_PC; m_valid = 1'b0; m_paid = 1'b0;
            if (m_fl_cnt != 32'hFFFF_FFFF) m_fl_cnt = m_fl_cnt + 1;
        end else if (h) begin
            m_paid = 1'b1;
            if (m_lu_cnt != 32'hFFFF_FFFF) m_lu_cnt = m_lu_cnt + 1;
        end else begin
            m_inst = IF_Inst; m_pc = IF_PC; m_valid = 1'b1; m_paid = 1'b0;
        end
    endtask

    task automatic drive(input logic rst, input logic [31:0] inst, input logic [31:0] pc,
                         input logic br, input logic jp, input logic ext,
                         input logic mr, input logic [4:0] rt);
        reset = rst; IF_Inst = inst; IF_PC = pc; Branch = br; Jump = jp;
        ext_stall = ext; EX_MemRead = mr; EX_Rt = rt;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        m_inst = 0; m_pc = 0; m_valid = 0; m_paid = 0; m_lu_cnt = 0; m_fl_cnt = 0;

        // Reset held for two edges with a load word presented.
        drive(0, 32'h8C220004, 32'h100, 0, 0, 0, 0, 5'd0);
        @(posedge clk);
        model_edge();
        #1;
        tick();
        chk("rst_inst",  ID_Inst, 32'h0);
        chk("rst_valid", {31'd0, ID_Valid}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        drive(1, 32'h8C220004, 32'h100, 0, 0, 0, 0, 5'd0);
        tick();
        chk("rel_inst",  ID_Inst, 32'h8C220004);
        chk("rel_valid", {31'd0, ID_Valid}, 32'd1);
        chk("rel_pc",    ID_PC, 32'h100);

        // Load-use on rs=2 costs exactly one cycle.
        drive(1, 32'h00431020, 32'h104, 0, 0, 0, 0, 5'd0);
        tick();
        drive(1, 32'h00001020, 32'h108, 0, 0, 0, 1, 5'd2);
        #1;
        chk("lu_stall",  {31'd0, stall},  32'd1);
        chk("lu_bubble", {31'd0, bubble}, 32'd1);
        tick();
        chk("lu_hold", ID_Inst, 32'h00431020);
        #1;
        chk("lu_one_cycle", {31'd0, stall}, 32'd0);
        tick();
        chk("lu_adv", ID_Inst, 32'h00001020);

        // A load into $0 never stalls, even though rs=0 matches.
        drive(1, 32'h00002020, 32'h10C, 0, 0, 0, 1, 5'd0);
        #1;
        chk("rt0_stall", {31'd0, stall}, 32'd0);
        tick();

        // Hazard and taken branch together: the branch wins.
        drive(1, 32'h00431020, 32'h110, 0, 0, 0, 0, 5'd0);
        tick();
        drive(1, 32'h00000000, 32'h200, 1, 0, 0, 1, 5'd3);
        #1;
        chk("br_stall",  {31'd0, stall},  32'd0);
        chk("br_bubble", {31'd0, bubble}, 32'd0);
        tick();
        chk("br_inst",  ID_Inst, 32'h0);
        chk("br_valid", {31'd0, ID_Valid}, 32'd0);
        chk("br_pc",    ID_PC, 32'h200);
        // FSM back in RUN: a fresh hazard stalls immediately.
        drive(1, 32'h00431020, 32'h204, 0, 0, 0, 0, 5'd0);
        tick();
        drive(1, 32'h00000000, 32'h208, 0, 0, 0, 1, 5'd2);
        #1;
        chk("run_again", {31'd0, stall}, 32'd1);
        tick();
        drive(1, 32'h11112222, 32'h300, 0, 0, 0, 0, 5'd0);
        tick();

        // Pipeline freeze with jumps pulsing: nothing in ID moves.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0, 32'h400 + i * 4, 0, (i != 1), 1, 0, 5'd0);
            #1;
            chk("frz_stall",  {31'd0, stall},  32'd1);
            chk("frz_bubble", {31'd0, bubble}, 32'd0);
            tick();
            chk("frz_inst",  ID_Inst, 32'h11112222);
            chk("frz_pc",    ID_PC, 32'h300);
            chk("frz_valid", {31'd0, ID_Valid}, 32'd1);
        end

        // Two more live flushes, giving three in total.
        drive(1, 32'h0, 32'h500, 0, 1, 0, 0, 5'd0);
        tick();
        drive(1, 32'h0, 32'h504, 1, 0, 0, 0, 5'd0);
        tick();
`ifdef IF_ID_PERF_EN
        chk("perf_lu", lu_stall_cnt, 32'd2);
        chk("perf_fl", flush_cnt, 32'd3);
`endif

        // Reset while sitting in the stall cycle.
        drive(1, 32'h00431020, 32'h600, 0, 0, 0, 0, 5'd0);
        tick();
        drive(1, 32'h0, 32'h604, 0, 0, 0, 1, 5'd3);
        tick();
        drive(0, 32'h0, 32'h604, 0, 0, 0, 1, 5'd3);
        tick();
        chk("mid_rst_inst", ID_Inst, 32'h0);
`ifdef IF_ID_PERF_EN
        chk("mid_rst_lu", lu_stall_cnt, 32'd0);
        chk("mid_rst_fl", flush_cnt, 32'd0);
`endif
        drive(1, 32'h00431020, 32'h700, 0, 0, 0, 0, 5'd0);
        tick();
        drive(1, 32'h0, 32'h704, 0, 0, 0, 1, 5'd3);
        #1;
        chk("mid_rst_run", {31'd0, stall}, 32'd1);
        tick();

        // Randomized traffic with small register numbers so hazards are frequent.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] inst;
            inst = {6'h23, 3'd0, 2'($urandom_range(0, 3)), 3'd0, 2'($urandom_range(0, 3)),
                    16'($urandom)};
            drive(($urandom_range(0, 99) >= 3), inst, $urandom,
                  ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 6),
                  ($urandom_range(0, 99) < 12), ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 3)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Pipeline boundary between the instruction-fetch stage and decode.
- Registers the fetched instruction and PC, tracks a valid bit and squashes on Branch/Jump.
- Detects MIPS load-use hazards against the instruction in EX.
- Drives the PC-hold stall back into fetch and a bubble request into the ID/EX register.

Parameters:
- DW, 32, instruction/PC width.
- RW, 5, register-specifier width.
- NOP_WORD, 32'h00000000, instruction injected on flush or reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- IF_Inst  in  DW  instruction from fetch (already zeroed by fetch on Branch/Jump)
- IF_PC  in  DW  PC of IF_Inst
- Branch  in  1  taken branch resolved this cycle
- Jump  in  1  jump resolved this cycle
- ext_stall  in  1  whole-pipeline freeze request from downstream
- EX_MemRead  in  1  instruction in EX is a load
- EX_Rt  in  RW  load destination register in EX
- ID_Inst  out  DW  registered instruction to decode
- ID_PC  out  DW  registered PC to decode
- ID_Valid  out  1  ID_Inst is a real instruction
- stall  out  1  hold PC in fetch (connects to fetch stall)
- bubble  out  1  ID/EX register must load a NOP this cycle

Behaviour:
- All updates happen on posedge clk. Reset is sampled only there (reset==0).
- Reset state: ID_Inst=NOP_WORD, ID_PC=0, ID_Valid=0, FSM=RUN, counters=0.
- Combinational outputs (stall, bubble) are 0 while reset==0.
- flush = Branch | Jump.
- hz = ID_Valid & EX_MemRead & (EX_Rt!=0) & (EX_Rt==ID_Inst[25:21] | EX_Rt==ID_Inst[20:16]). hz is masked to 0 in state LU_STALL.
- stall = ext_stall | (hz & ~flush).
- bubble = hz & ~flush & ~ext_stall.
- Register update priority, highest first:
  1. reset
  2. ext_stall: hold all, including during flush, because the whole pipe is frozen and the branch source is held too
  3. flush: ID_Inst=NOP_WORD, ID_Valid=0, ID_PC=IF_PC
  4. hz: hold ID_Inst/ID_PC/ID_Valid
  5. otherwise load ID_Inst=IF_Inst, ID_PC=IF_PC, ID_Valid=1
- FSM states: RUN, LU_STALL.
  - RUN→LU_STALL when hz & ~flush & ~ext_stall.
  - LU_STALL→RUN on the next non-ext_stall edge. LU_STALL holds while ext_stall.
  - flush in LU_STALL → RUN plus flush action.
- Load-use costs exactly one cycle. A second consecutive hazard on the same instruction is impossible because EX then holds the bubble; masking guarantees this.
- Latency: IF→ID is one cycle. The stall output is same-cycle combinational.
- Simultaneous flush+hz: flush wins, no stall, so the fetch redirect is not lost.
- Reset mid-stall: FSM returns to RUN and the held instruction is discarded.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- With the macro defined:
  - Adds output ports lu_stall_cnt [31:0] and flush_cnt [31:0].
  - lu_stall_cnt increments on each RUN→LU_STALL transition.
  - flush_cnt increments on each non-frozen flush edge.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Without the macro: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package: RS_MSB/RS_LSB (25/21), RT_MSB/RT_LSB (20/16), NOP_WORD, FSM state encoding (RUN=1'b0, LU_STALL=1'b1).
- One sub-module: load_use_detect. Purely combinational hz computation from ID_Inst, ID_Valid, EX_MemRead, EX_Rt and the state mask. It is reused later by a forwarding unit.

Test Plan:
- reset=0 for 2 edges with IF_Inst=32'h8C220004 → ID_Inst=0, ID_Valid=0, stall=0. Release: the next edge gives ID_Inst=32'h8C220004, ID_Valid=1, ID_PC=IF_PC.
- ID_Inst=32'h00431020 (add rs=2, rt=3), EX_MemRead=1, EX_Rt=2 → stall=1 and bubble=1 for exactly one cycle. ID_Inst is held, the next cycle has stall=0 and the instruction advances.
- EX_MemRead=1, EX_Rt=0 matching rs=0 → no stall.
- Hazard condition plus Branch=1 in the same cycle → stall=0, bubble=0. The next edge gives ID_Inst=0, ID_Valid=0, FSM=RUN.
- ext_stall=1 for 3 cycles with Jump pulsing → ID_Inst, ID_PC and ID_Valid unchanged, stall=1, bubble=0.
- With IF_ID_PERF_EN: 2 load-use events and 3 flushes → lu_stall_cnt=2, flush_cnt=3. Reset mid-LU_STALL → counters 0, FSM RUN.
